// File: rtl/vga_timing.sv
// Raster timing generator: pixel coordinates, sync, display enable and strobes.
// Optional frame counter / animation phase, built only when VGA_TIMING_ANIM_EN is defined.
module vga_timing #(
   parameter int VGA_WIDTH       = 640,
   parameter int VGA_HEIGHT      = 480,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_SYNC_PULSE    = 96,
   parameter int H_BACK_PORCH    = 48,
   parameter int V_FRONT_PORCH   = 10,
   parameter int V_SYNC_PULSE    = 2,
   parameter int V_BACK_PORCH    = 33,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int FRAME_BITS      = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ce_i,
   output logic [$clog2(VGA_WIDTH+H_FRONT_PORCH+H_SYNC_PULSE+H_BACK_PORCH)-1:0] pixel_x_o,
   output logic [$clog2(VGA_HEIGHT+V_FRONT_PORCH+V_SYNC_PULSE+V_BACK_PORCH)-1:0] pixel_y_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  display_en_o,
   output logic                  line_start_o,
   output logic                  frame_start_o,
   output logic [FRAME_BITS-1:0] frame_count_o,
   output logic                  anim_phase_o
);

   localparam int H_TOTAL  = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOTAL  = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam int XW       = $clog2(H_TOTAL);
   localparam int YW       = $clog2(V_TOTAL);
   localparam int HS_START = VGA_WIDTH + H_FRONT_PORCH;
   localparam int HS_END   = HS_START + H_SYNC_PULSE;
   localparam int VS_START = VGA_HEIGHT + V_FRONT_PORCH;
   localparam int VS_END   = VS_START + V_SYNC_PULSE;
   localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

   logic [XW-1:0] hx_q, hx_d;
   logic [YW-1:0] vy_q, vy_d;
   logic [XW-1:0] pixel_x_q;
   logic [YW-1:0] pixel_y_q;
   logic          hsync_q, vsync_q, display_en_q, line_start_q, frame_start_q;
   logic          hsync_d, vsync_d, display_en_d, line_start_d, frame_start_d;
   logic [31:0]   hx_w, vy_w;

   // Widen the counters so every comparison runs at full integer width.
   assign hx_w = 32'(hx_q);
   assign vy_w = 32'(vy_q);

   always_comb begin
      hx_d = hx_q + XW'(1);
      vy_d = vy_q;
      if (hx_w == 32'(H_TOTAL - 1)) begin
         hx_d = '0;
         if (vy_w == 32'(V_TOTAL - 1)) begin
            vy_d = '0;
         end else begin
            vy_d = vy_q + YW'(1);
         end
      end
      display_en_d  = (hx_w < 32'(VGA_WIDTH)) && (vy_w < 32'(VGA_HEIGHT));
      hsync_d       = ((hx_w >= 32'(HS_START)) && (hx_w < 32'(HS_END))) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = ((vy_w >= 32'(VS_START)) && (vy_w < 32'(VS_END))) ? SYNC_ON : ~SYNC_ON;
      line_start_d  = (hx_q == '0);
      frame_start_d = (hx_q == '0) && (vy_q == '0);
   end

   // The output stage captures the decode of the current counter position,
   // so the whole tuple lags the counters by exactly one enabled edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hx_q          <= '0;
         vy_q          <= '0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
         display_en_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (ce_i) begin
         hx_q          <= hx_d;
         vy_q          <= vy_d;
         pixel_x_q     <= hx_q;
         pixel_y_q     <= vy_q;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_en_q  <= display_en_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pixel_x_o     = pixel_x_q;
   assign pixel_y_o     = pixel_y_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign display_en_o  = display_en_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

`ifdef VGA_TIMING_ANIM_EN
   logic [FRAME_BITS-1:0] frame_count_q;
   logic                  seen_frame_q;

   // The first frame after reset presents count 0; later frame starts bump it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_count_q <= '0;
         seen_frame_q  <= 1'b0;
      end else if (ce_i && frame_start_d) begin
         seen_frame_q <= 1'b1;
         if (seen_frame_q) begin
            frame_count_q <= frame_count_q + FRAME_BITS'(1);
         end
      end
   end

   assign frame_count_o = frame_count_q;
   assign anim_phase_o  = frame_count_q[FRAME_BITS-1];
`else
   assign frame_count_o = '0;
   assign anim_phase_o  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: directed vector table on a default-size instance and a
// scoreboarded run of a miniature raster (active-high sync) over 33+ frames.
module tb_vga_timing;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance A: default parameters ----------------
   logic       a_rst = 1'b1, a_ce = 1'b0;
   logic [9:0] a_x, a_y;
   logic       a_hs, a_vs, a_de, a_ls, a_fs, a_ap;
   logic [4:0] a_fc;

   vga_timing dut_a (
      .clk_i(clk), .rst_i(a_rst), .ce_i(a_ce),
      .pixel_x_o(a_x), .pixel_y_o(a_y), .hsync_o(a_hs), .vsync_o(a_vs),
      .display_en_o(a_de), .line_start_o(a_ls), .frame_start_o(a_fs),
      .frame_count_o(a_fc), .anim_phase_o(a_ap)
   );

   // ---------------- instance B: 15 x 11 raster, active-high sync ----------------
   localparam int TW = 19;
   logic       b_rst = 1'b1, b_ce = 1'b0;
   logic [3:0] b_x, b_y;
   logic       b_hs, b_vs, b_de, b_ls, b_fs, b_ap;
   logic [4:0] b_fc;

   vga_timing #(
      .VGA_WIDTH(8), .VGA_HEIGHT(6),
      .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
      .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
      .SYNC_ACTIVE_LOW(0), .FRAME_BITS(5)
   ) dut_b (
      .clk_i(clk), .rst_i(b_rst), .ce_i(b_ce),
      .pixel_x_o(b_x), .pixel_y_o(b_y), .hsync_o(b_hs), .vsync_o(b_vs),
      .display_en_o(b_de), .line_start_o(b_ls), .frame_start_o(b_fs),
      .frame_count_o(b_fc), .anim_phase_o(b_ap)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // ---------------- vector table for instance A ----------------
   typedef struct {
      logic rst; logic ce; int cycles;
      int x; int y; logic hs; logic vs; logic de; logic ls; logic fs;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic rst, input logic ce, input int cycles,
                               input int x, input int y, input logic hs, input logic vs,
                               input logic de, input logic ls, input logic fs);
      vec_t v;
      v.rst = rst; v.ce = ce; v.cycles = cycles; v.x = x; v.y = y;
      v.hs = hs; v.vs = vs; v.de = de; v.ls = ls; v.fs = fs;
      return v;
   endfunction

   task automatic a_apply(input int idx, input vec_t v);
      logic [31:0] got, exp;
      for (int n = 0; n < v.cycles; n++) begin
         a_rst = v.rst;
         a_ce  = v.ce;
         @(posedge clk);
         #1;
      end
      got = {6'd0, a_x, a_y, a_hs, a_vs, a_de, a_ls, a_fs};
      exp = {6'd0, 10'(v.x), 10'(v.y), v.hs, v.vs, v.de, v.ls, v.fs};
      chk($sformatf("a_vec%0d", idx), got, exp);
      chk($sformatf("a_vec%0d_fc", idx), {26'd0, a_fc, a_ap}, 32'd0);
   endtask

   // ---------------- reference model + scoreboard for instance B ----------------
   logic [TW-1:0] exp_q[$];
   int            m_hx = 0, m_vy = 0;
   logic [4:0]    m_fc = 5'd0;
   bit            m_seen = 1'b0;
   logic [TW-1:0] m_last = '0;
   int            cnt_hs, cnt_vs, cnt_de, cnt_ls, cnt_fs;

   task automatic b_cycle(input logic r, input logic c);
      logic [TW-1:0] e, got;
      logic hs, vs, de, ls, fs;
      b_rst = r;
      b_ce  = c;
      if (r) begin
         e = '0;
         m_hx = 0; m_vy = 0; m_fc = 5'd0; m_seen = 1'b0;
      end else if (c) begin
         de = (m_hx < 8) && (m_vy < 6);
         hs = (m_hx >= 10) && (m_hx <= 12);
         vs = (m_vy >= 7) && (m_vy <= 8);
         ls = (m_hx == 0);
         fs = ls && (m_vy == 0);
`ifdef VGA_TIMING_ANIM_EN
         if (fs) begin
            if (m_seen) m_fc = m_fc + 5'd1;
            m_seen = 1'b1;
         end
`endif
         e = {4'(m_hx), 4'(m_vy), hs, vs, de, ls, fs, m_fc, m_fc[4]};
         m_hx++;
         if (m_hx == 15) begin
            m_hx = 0;
            m_vy++;
            if (m_vy == 11) m_vy = 0;
         end
      end else begin
         e = m_last;
      end
      m_last = e;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = {b_x, b_y, b_hs, b_vs, b_de, b_ls, b_fs, b_fc, b_ap};
      chk("b_tuple", 32'(got), 32'(exp_q.pop_front()));
      if (c && !r) begin
         cnt_hs += int'(b_hs);
         cnt_vs += int'(b_vs);
         cnt_de += int'(b_de);
         cnt_ls += int'(b_ls);
         cnt_fs += int'(b_fs);
      end
   endtask

   initial begin
      logic [4:0] prev_fc;
      logic       prev_ap;
      int         wraps, ap_rise, ap_fall, adv, exp_wraps, exp_edges;

      vecs[0]  = mk(1, 1, 3,   0,   0, 1, 1, 0, 0, 0);
      vecs[1]  = mk(1, 0, 1,   0,   0, 1, 1, 0, 0, 0);
      vecs[2]  = mk(0, 1, 1,   0,   0, 1, 1, 1, 1, 1);
      vecs[3]  = mk(0, 1, 1,   1,   0, 1, 1, 1, 0, 0);
      vecs[4]  = mk(0, 1, 638, 639, 0, 1, 1, 1, 0, 0);
      vecs[5]  = mk(0, 1, 1,   640, 0, 1, 1, 0, 0, 0);
      vecs[6]  = mk(0, 1, 15,  655, 0, 1, 1, 0, 0, 0);
      vecs[7]  = mk(0, 0, 5,   655, 0, 1, 1, 0, 0, 0);
      vecs[8]  = mk(0, 1, 1,   656, 0, 0, 1, 0, 0, 0);
      vecs[9]  = mk(0, 1, 95,  751, 0, 0, 1, 0, 0, 0);
      vecs[10] = mk(0, 1, 1,   752, 0, 1, 1, 0, 0, 0);
      vecs[11] = mk(0, 1, 47,  799, 0, 1, 1, 0, 0, 0);
      vecs[12] = mk(0, 1, 1,   0,   1, 1, 1, 1, 1, 0);
      vecs[13] = mk(0, 1, 100, 100, 1, 1, 1, 1, 0, 0);
      vecs[14] = mk(1, 1, 1,   0,   0, 1, 1, 0, 0, 0);
      vecs[15] = mk(0, 1, 1,   0,   0, 1, 1, 1, 1, 1);

      for (int i = 0; i < 16; i++) a_apply(i, vecs[i]);
      a_rst = 1'b1;

      // B: reset, then one full frame counting strobe and sync positions.
      b_cycle(1, 1);
      b_cycle(1, 1);
      cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_ls = 0; cnt_fs = 0;
      for (int i = 0; i < 165; i++) b_cycle(0, 1);
      chk("b_hs_edges", 32'(cnt_hs), 32'd33);
      chk("b_vs_edges", 32'(cnt_vs), 32'd30);
      chk("b_de_edges", 32'(cnt_de), 32'd48);
      chk("b_ls_edges", 32'(cnt_ls), 32'd11);
      chk("b_fs_edges", 32'(cnt_fs), 32'd1);
      b_cycle(0, 1);
      chk("b_frame_period_fs", {31'd0, b_fs}, 32'd1);
      chk("b_frame_period_xy", {24'd0, b_x, b_y}, 32'd0);

      // 32 more frames with random ce stalls; watch counter wrap and phase edges.
      wraps = 0; ap_rise = 0; ap_fall = 0; adv = 0;
      prev_fc = b_fc; prev_ap = b_ap;
      while (adv < 32 * 165) begin
         logic c;
         c = ($urandom_range(0, 7) != 0);
         b_cycle(0, c);
         if (c) adv++;
         if (prev_fc == 5'd31 && b_fc == 5'd0) wraps++;
         if (!prev_ap && b_ap) ap_rise++;
         if (prev_ap && !b_ap) ap_fall++;
         prev_fc = b_fc; prev_ap = b_ap;
      end
`ifdef VGA_TIMING_ANIM_EN
      exp_wraps = 1;
      exp_edges = 1;
`else
      exp_wraps = 0;
      exp_edges = 0;
`endif
      chk("b_fc_wraps", 32'(wraps), 32'(exp_wraps));
      chk("b_ap_rise", 32'(ap_rise), 32'(exp_edges));
      chk("b_ap_fall", 32'(ap_fall), 32'(exp_edges));

      // Mid-frame reset with ce low, then restart from (0,0) with count 0.
      for (int i = 0; i < 49; i++) b_cycle(0, 1);
      b_cycle(1, 0);
      b_cycle(0, 0);
      chk("b_rst_hold_x", {28'd0, b_x}, 32'd0);
      b_cycle(0, 1);
      chk("b_restart_fs", {31'd0, b_fs}, 32'd1);
      chk("b_restart_fc", {27'd0, b_fc}, 32'd0);
      for (int i = 0; i < 200; i++) b_cycle(0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
# vga_timing

Upstream raster timing generator for the VGA output path. It produces the pixel coordinates, sync pulses, display-enable flag and frame/line strobes that the graphics stage turns into the `vga_pmod` byte. All outputs for one pixel position come from a single register stage, so the graphics stage can register its colour lookup against them with a fixed one-cycle offset. It also owns the frame counter that selects the animation phase.

## Interface

Parameters:
- `VGA_WIDTH`, default 640: active pixels per line.
- `VGA_HEIGHT`, default 480: active lines per frame.
- `H_FRONT_PORCH` 16, `H_SYNC_PULSE` 96, `H_BACK_PORCH` 48: horizontal blanking, in pixels.
- `V_FRONT_PORCH` 10, `V_SYNC_PULSE` 2, `V_BACK_PORCH` 33: vertical blanking, in lines.
- `SYNC_ACTIVE_LOW`, default 1: 1 drives sync low during the pulse; 0 drives it high.
- `FRAME_BITS`, default 5: width of `frame_count`.

Ports (H_TOTAL = 800 and V_TOTAL = 525 at the defaults):
- `clk`  in  1: pixel-domain clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `ce`  in  1: pixel advance enable. When low, every register holds.
- `pixel_x`  out  clog2(H_TOTAL): current column.
- `pixel_y`  out  clog2(V_TOTAL): current line.
- `hsync`  out  1: horizontal sync, polarity set by `SYNC_ACTIVE_LOW`.
- `vsync`  out  1: vertical sync, same polarity rule.
- `display_en`  out  1: high when the position is inside the active area.
- `line_start`  out  1: high for the position where x = 0.
- `frame_start`  out  1: high for the position where x = 0 and y = 0.
- `frame_count`  out  FRAME_BITS: number of completed frames, modulo 2^FRAME_BITS.
- `anim_phase`  out  1: equals `frame_count[FRAME_BITS-1]`.

## Operation

- An internal counter pair (hx, vy) feeds one output register stage that holds the whole tuple. All outputs are registered.
- hx counts from 0 to H_TOTAL-1 and then wraps to 0. vy advances by 1 when hx wraps. When vy wraps from V_TOTAL-1, it returns to 0.
- Decode applied to each presented position (x, y):
  - `display_en` = (x < VGA_WIDTH) and (y < VGA_HEIGHT).
  - Horizontal sync is active for x in [VGA_WIDTH+H_FRONT_PORCH, VGA_WIDTH+H_FRONT_PORCH+H_SYNC_PULSE-1], which is [656, 751] at the defaults.
  - Vertical sync is active for y in [VGA_HEIGHT+V_FRONT_PORCH, VGA_HEIGHT+V_FRONT_PORCH+V_SYNC_PULSE-1], which is [490, 491] at the defaults. This holds for every x of those lines.
  - `line_start` = (x == 0). `frame_start` = (x == 0 and y == 0).
- `frame_count` increments by 1 in the same cycle that presents `frame_start` for every frame except the first one after reset. It wraps from 2^FRAME_BITS-1 to 0 with no saturation.
- Coordinate arithmetic is unsigned. Comparisons use the parameter sums at full integer width.

## Timing

- A rising edge with `rst` = 1 forces:
  - hx = vy = 0;
  - `pixel_x` = `pixel_y` = 0;
  - `hsync` and `vsync` to their inactive level (1 when `SYNC_ACTIVE_LOW` = 1, 0 otherwise);
  - `display_en` = `line_start` = `frame_start` = 0;
  - `frame_count` = 0.
- `rst` takes priority over `ce`. Asserting reset mid-frame discards the current position, and the next frame starts from (0,0) with `frame_count` = 0.
- The k-th rising edge with `rst` = 0 and `ce` = 1 (k ≥ 1) presents the tuple for raster position k-1. The first such edge therefore presents (0,0) with `display_en` = 1, `line_start` = 1, `frame_start` = 1 and `frame_count` = 0.
- Latency from counter to outputs is exactly 1 edge. All tuple fields stay mutually aligned, with no skew between the sync signals and the coordinates.
- With `ce` = 0 the outputs and counters hold their values. Strobes stay at their held value; they are not pulsed again on a stall.
- The strobes are one position wide (one `ce` cycle).

## Configuration

- `VGA_TIMING_ANIM_EN` defined: `frame_count` and `anim_phase` behave as described in Operation.
- `VGA_TIMING_ANIM_EN` undefined:
  - The frame counter register is not built.
  - `frame_count` is tied to 0 and `anim_phase` is tied to 0.
  - All raster and sync behaviour is unchanged.

## Test plan

- Reset values: hold `rst` = 1 for 3 cycles with defaults and `ce` = 1 → `hsync` = `vsync` = 1, `display_en` = 0, `frame_count` = 0. On the first edge after release: (0,0), `display_en` = 1, `frame_start` = 1.
- Line timing: run one line → `display_en` falls on x = 640; `hsync` is low exactly for x = 656..751 (96 edges); x goes 799 → 0 with y+1 and `line_start` = 1.
- Frame timing: run one frame → `vsync` is low for y = 490..491, which is 1600 edges; the frame lasts 420000 edges; `frame_start` appears once per frame; `frame_count` goes 0 → 1 on the second `frame_start`.
- Frame counter wrap: run 32 frames → `frame_count` wraps 31 → 0; `anim_phase` rises when `frame_count` reaches 16 and falls when it wraps to 0.
- `ce` stall: pulse `ce` low for 5 cycles at x = 655 → the tuple holds at 655, then `hsync` asserts on the first enabled edge at 656. Then assert `rst` at y = 300 → outputs take their reset values on the next edge, and the restart begins at (0,0) with `frame_count` = 0.
- Build with `VGA_TIMING_ANIM_EN` undefined and run 20 frames → `frame_count` = 0 and `anim_phase` = 0 throughout, with sync timing identical to the line and frame timing scenarios.
